// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and two-level operand forwarding into the ALU inputs.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_aluop,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic             id_alusrc,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             flush,
  input  logic             stall_in,
  input  logic             exm_reg_write,
  input  logic [4:0]       exm_rd,
  input  logic [31:0]      exm_result,
  input  logic             mwb_reg_write,
  input  logic [4:0]       mwb_rd,
  input  logic [31:0]      mwb_data,
  output logic [3:0]       ALUop,
  output logic [31:0]      in1,
  output logic [31:0]      in2,
  output logic             ex_valid,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [31:0]      ex_store_data,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             ex_valid_reg;
  logic [3:0]       ex_aluop_reg;
  logic [4:0]       ex_rs_reg;
  logic [4:0]       ex_rt_reg;
  logic [4:0]       ex_rd_reg;
  logic [31:0]      ex_rs_data_reg;
  logic [31:0]      ex_rt_data_reg;
  logic [31:0]      ex_imm_reg;
  logic             ex_alusrc_reg;
  logic             ex_mem_read_reg;
  logic             ex_mem_write_reg;
  logic             ex_reg_write_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  logic             rs_match;
  logic             rt_match;

  // A load in EX whose destination feeds the instruction in ID cannot be
  // forwarded in time; rt only matters when it is actually read as in2.
  assign rs_match = (id_rs == ex_rd_reg);
  assign rt_match = !id_alusrc && (id_rt == ex_rd_reg);
  assign hazard_stall = id_valid && ex_valid_reg && ex_mem_read_reg &&
                        (ex_rd_reg != 5'd0) && (rs_match || rt_match) &&
                        !stall_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg     <= 1'b0;
      ex_aluop_reg     <= 4'd0;
      ex_rs_reg        <= 5'd0;
      ex_rt_reg        <= 5'd0;
      ex_rd_reg        <= 5'd0;
      ex_rs_data_reg   <= 32'd0;
      ex_rt_data_reg   <= 32'd0;
      ex_imm_reg       <= 32'd0;
      ex_alusrc_reg    <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      ex_mem_write_reg <= 1'b0;
      ex_reg_write_reg <= 1'b0;
      bubble_cnt_reg   <= '0;
    end else if (stall_in) begin
      // Whole stage holds; nothing to assign.
    end else if (flush || hazard_stall) begin
      // Bubble: only the control bits matter, data registers are left as-is.
      ex_valid_reg     <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      ex_mem_write_reg <= 1'b0;
      ex_reg_write_reg <= 1'b0;
      if (!flush && (bubble_cnt_reg != {CNT_W{1'b1}}))
        bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
    end else begin
      ex_valid_reg     <= id_valid;
      ex_aluop_reg     <= id_aluop;
      ex_rs_reg        <= id_rs;
      ex_rt_reg        <= id_rt;
      ex_rd_reg        <= id_rd;
      ex_rs_data_reg   <= id_rs_data;
      ex_rt_data_reg   <= id_rt_data;
      ex_imm_reg       <= id_imm;
      ex_alusrc_reg    <= id_alusrc;
      ex_mem_read_reg  <= id_mem_read;
      ex_mem_write_reg <= id_mem_write;
      ex_reg_write_reg <= id_reg_write;
    end
  end

  // Operand 0 is rs, operand 1 is rt; EX/MEM is younger so it wins.
  logic [4:0]  src_idx [2];
  logic [31:0] src_raw [2];
  logic [31:0] src_fwd [2];

  assign src_idx[0] = ex_rs_reg;
  assign src_idx[1] = ex_rt_reg;
  assign src_raw[0] = ex_rs_data_reg;
  assign src_raw[1] = ex_rt_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign src_fwd[gi] =
        (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == src_idx[gi])) ? exm_result :
        (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == src_idx[gi])) ? mwb_data :
        src_raw[gi];
    end
  endgenerate

  assign in1           = src_fwd[0];
  assign in2           = ex_alusrc_reg ? ex_imm_reg : src_fwd[1];
  assign ex_store_data = src_fwd[1];
  assign ALUop         = ex_valid_reg ? ex_aluop_reg : 4'd0;

  assign ex_valid      = ex_valid_reg;
  assign ex_rd         = ex_rd_reg;
  assign ex_reg_write  = ex_reg_write_reg;
  assign ex_mem_read   = ex_mem_read_reg;
  assign ex_mem_write  = ex_mem_write_reg;
  assign bubble_cnt    = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: load, forwarding, load-use bubbles,
// stall/flush priority, saturation and mid-operation reset.
module tb_id_ex_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [3:0]       id_aluop;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic [31:0]      id_rs_data, id_rt_data, id_imm;
  logic             id_alusrc, id_mem_read, id_mem_write, id_reg_write;
  logic             flush, stall_in;
  logic             exm_reg_write, mwb_reg_write;
  logic [4:0]       exm_rd, mwb_rd;
  logic [31:0]      exm_result, mwb_data;
  logic [3:0]       ALUop;
  logic [31:0]      in1, in2, ex_store_data;
  logic             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]       ex_rd;
  logic             hazard_stall;
  logic [CNT_W-1:0] bubble_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_bubbles = 0;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_aluop(id_aluop),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .flush(flush), .stall_in(stall_in),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .ALUop(ALUop), .in1(in1), .in2(in2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .hazard_stall(hazard_stall),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are settled 1ns later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d: ex_valid=%0b ex_rd=%0d ALUop=%0d in1=%h in2=%h hz=%0b bubbles=%0d",
             cyc, ex_valid, ex_rd, ALUop, in1, in2, hazard_stall, bubble_cnt);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_aluop = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alusrc = 0;
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
    flush = 0; stall_in = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
  endtask

  task automatic present(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic alusrc, input logic mr,
                         input logic mw, input logic rw);
    id_valid = 1; id_aluop = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alusrc = alusrc;
    id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    n_vec++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
    n_vec++; if (ALUop !== 4'd0) begin n_fail++; $display("FAIL reset_aluop: got %0d want 0", ALUop); end
    n_vec++; if (in1 !== 32'd0 || in2 !== 32'd0) begin n_fail++; $display("FAIL reset_operands: got %h/%h want 0/0", in1, in2); end
    n_vec++; if (bubble_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_bubbles: got %0d want 0", bubble_cnt); end
    n_vec++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %0b want 0", hazard_stall); end
  endtask

  task automatic test_load();
    present(4'd0, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    n_vec++; if (in1 !== 32'd5 || in2 !== 32'd7) begin n_fail++; $display("FAIL load_operands: got %h/%h want 5/7", in1, in2); end
    n_vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL load_ctrl: got v=%0b rd=%0d rw=%0b want 1/9/1", ex_valid, ex_rd, ex_reg_write); end
    n_vec++; if (ex_store_data !== 32'd7) begin n_fail++; $display("FAIL load_store_data: got %h want 7", ex_store_data); end
    present(4'd9, 5'd3, 5'd4, 5'd10, 32'd5, 32'd7, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    n_vec++; if (ALUop !== 4'd9) begin n_fail++; $display("FAIL load_aluop: got %0d want 9", ALUop); end
    n_vec++; if (in2 !== 32'hFFFF_FFF0 || ex_store_data !== 32'd7) begin
      n_fail++; $display("FAIL load_imm: got in2=%h st=%h want fffffff0/7", in2, ex_store_data); end
    n_vec++; if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL load_mw: got mw=%0b rw=%0b want 1/0", ex_mem_write, ex_reg_write); end
    id_valid = 0;
    tick();
    n_vec++; if (ex_valid !== 1'b0 || ALUop !== 4'd0) begin
      n_fail++; $display("FAIL load_invalid: got v=%0b op=%0d want 0/0", ex_valid, ALUop); end
  endtask

  task automatic test_forward();
    present(4'd0, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    id_valid = 0;
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'h10;
    mwb_reg_write = 1; mwb_rd = 3; mwb_data = 32'h20;
    #1;
    n_vec++; if (in1 !== 32'h10) begin n_fail++; $display("FAIL fwd_exm_priority: got %h want 10", in1); end
    exm_reg_write = 0; #1;
    n_vec++; if (in1 !== 32'h20) begin n_fail++; $display("FAIL fwd_mwb: got %h want 20", in1); end
    mwb_reg_write = 0; #1;
    n_vec++; if (in1 !== 32'd5) begin n_fail++; $display("FAIL fwd_none: got %h want 5", in1); end
    exm_reg_write = 1; exm_rd = 4; exm_result = 32'hABCD; #1;
    n_vec++; if (in2 !== 32'hABCD || ex_store_data !== 32'hABCD || in1 !== 32'd5) begin
      n_fail++; $display("FAIL fwd_rt: got in1=%h in2=%h st=%h want 5/abcd/abcd", in1, in2, ex_store_data); end
    exm_reg_write = 0; exm_rd = 0;
    present(4'd0, 5'd0, 5'd0, 5'd9, 32'h55, 32'h66, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    id_valid = 0;
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'h10;
    mwb_reg_write = 1; mwb_rd = 0; mwb_data = 32'h20;
    #1;
    n_vec++; if (in1 !== 32'h55 || in2 !== 32'h66) begin
      n_fail++; $display("FAIL fwd_r0: got %h/%h want 55/66", in1, in2); end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    // lw r8 enters EX
    present(4'd0, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0, 32'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    present(4'd0, 5'd8, 5'd5, 5'd11, 32'h77, 32'h33, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    n_vec++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL lu_hazard_rs: got %0b want 1", hazard_stall); end
    tick();
    exp_bubbles++;
    n_vec++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble: got v=%0b mr=%0b rw=%0b want 0/0/0", ex_valid, ex_mem_read, ex_reg_write); end
    n_vec++; if (bubble_cnt !== 4'(exp_bubbles)) begin n_fail++; $display("FAIL lu_count: got %0d want %0d", bubble_cnt, exp_bubbles); end
    n_vec++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_hazard_clear: got %0b want 0", hazard_stall); end
    tick();
    n_vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd11 || in1 !== 32'h77) begin
      n_fail++; $display("FAIL lu_enter: got v=%0b rd=%0d in1=%h want 1/11/77", ex_valid, ex_rd, in1); end
    // Load to r0 never stalls
    present(4'd0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    present(4'd0, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    n_vec++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_r0: got %0b want 0", hazard_stall); end
  endtask

  task automatic test_alusrc();
    present(4'd0, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0, 32'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    present(4'd0, 5'd1, 5'd8, 5'd13, 32'h9, 32'h44, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    n_vec++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL alusrc_rt_hazard: got %0b want 1", hazard_stall); end
    id_alusrc = 1; #1;
    n_vec++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL alusrc_no_hazard: got %0b want 0", hazard_stall); end
    tick();
    n_vec++; if (ex_valid !== 1'b1 || in2 !== 32'h100 || in1 !== 32'h9) begin
      n_fail++; $display("FAIL alusrc_imm: got v=%0b in1=%h in2=%h want 1/9/100", ex_valid, in1, in2); end
    n_vec++; if (bubble_cnt !== 4'(exp_bubbles)) begin n_fail++; $display("FAIL alusrc_count: got %0d want %0d", bubble_cnt, exp_bubbles); end
    idle_inputs();
  endtask

  task automatic test_stall_flush();
    // EX: load r6 (rs=3 data 5); ID: consumer of r6 would otherwise stall.
    present(4'd2, 5'd3, 5'd4, 5'd6, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    present(4'd1, 5'd6, 5'd1, 5'd14, 32'h99, 32'h98, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    stall_in = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL stall_hazard_masked[%0d]: got %0b want 0", i, hazard_stall); end
      tick();
      n_vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_mem_read !== 1'b1 || in1 !== 32'd5 || ALUop !== 4'd2) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%0b rd=%0d mr=%0b in1=%h op=%0d want 1/6/1/5/2",
                           i, ex_valid, ex_rd, ex_mem_read, in1, ALUop); end
      n_vec++; if (bubble_cnt !== 4'(exp_bubbles)) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want %0d", i, bubble_cnt, exp_bubbles); end
    end
    stall_in = 0; #1;
    n_vec++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL release_hazard: got %0b want 1", hazard_stall); end
    tick();
    n_vec++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0 || ALUop !== 4'd0) begin
      n_fail++; $display("FAIL flush_apply: got v=%0b mr=%0b rw=%0b op=%0d want 0/0/0/0", ex_valid, ex_mem_read, ex_reg_write, ALUop); end
    n_vec++; if (bubble_cnt !== 4'(exp_bubbles)) begin n_fail++; $display("FAIL flush_count: got %0d want %0d", bubble_cnt, exp_bubbles); end
    idle_inputs();
  endtask

  task automatic make_bubble();
    present(4'd0, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0, 32'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    present(4'd0, 5'd8, 5'd5, 5'd11, 32'h77, 32'h33, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    if (exp_bubbles < 15) exp_bubbles++;
  endtask

  task automatic test_reset_mid();
    while (exp_bubbles < 5) make_bubble();
    present(4'd4, 5'd3, 5'd4, 5'd9, 32'hDEAD, 32'hBEEF, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    n_vec++; if (ex_valid !== 1'b1 || bubble_cnt !== 4'd5) begin
      n_fail++; $display("FAIL pre_reset: got v=%0b cnt=%0d want 1/5", ex_valid, bubble_cnt); end
    rst = 1; stall_in = 1; flush = 1;
    tick();
    rst = 0; stall_in = 0; flush = 0; id_valid = 0;
    #1;
    n_vec++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0) begin
      n_fail++; $display("FAIL rst_ctrl: got v=%0b rd=%0d rw=%0b mr=%0b mw=%0b want all 0",
                         ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write); end
    n_vec++; if (ALUop !== 4'd0 || in1 !== 32'd0 || in2 !== 32'd0 || ex_store_data !== 32'd0) begin
      n_fail++; $display("FAIL rst_data: got op=%0d in1=%h in2=%h st=%h want all 0", ALUop, in1, in2, ex_store_data); end
    n_vec++; if (bubble_cnt !== 4'd0 || hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_count: got cnt=%0d hz=%0b want 0/0", bubble_cnt, hazard_stall); end
    exp_bubbles = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      make_bubble();
      n_vec++; if (bubble_cnt !== 4'(exp_bubbles)) begin
        n_fail++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, bubble_cnt, exp_bubbles); end
    end
    n_vec++; if (bubble_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_final: got %0d want 15", bubble_cnt); end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_load();
    test_forward();
    test_load_use();
    test_alusrc();
    test_stall_flush();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: CNT_W, 16, width of bubble counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_valid  in  1  decoded instruction present from ID.
REQ-005 id_aluop  in  4  ALU opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT).
REQ-006 id_rs, id_rt, id_rd  in  5 each  source/destination register indices.
REQ-007 id_rs_data, id_rt_data, id_imm  in  32 each  register-file reads, sign/zero-extended immediate.
REQ-008 id_alusrc  in  1  1 = in2 takes immediate; rt then unused for hazard detection.
REQ-009 id_mem_read, id_mem_write, id_reg_write  in  1 each  control bits carried to EX.
REQ-010 flush  in  1  kill instruction entering EX (branch redirect).
REQ-011 stall_in  in  1  downstream stall; whole stage holds.
REQ-012 exm_reg_write, exm_rd, exm_result  in  1/5/32  EX/MEM forwarding source.
REQ-013 mwb_reg_write, mwb_rd, mwb_data  in  1/5/32  MEM/WB forwarding source.
REQ-014 ALUop, in1, in2  out  4/32/32  operands to ALU.
REQ-015 ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write  out  1/5/1/1/1  registered EX control.
REQ-016 ex_store_data  out  32  forwarded rt value for stores.
REQ-017 hazard_stall  out  1  combinational; ID/IF must hold when 1.
REQ-018 bubble_cnt  out  CNT_W  count of bubbles inserted.

Function
REQ-019 Update priority each edge: rst > stall_in > flush > hazard_stall > normal load.
REQ-020 Normal load: all id_* fields registered; ex_valid <= id_valid; latency one cycle ID to ALU inputs.
REQ-021 stall_in=1: all EX registers and bubble_cnt hold; hazard_stall forced 0.
REQ-022 flush=1 (no stall_in): ex_valid, ex_reg_write, ex_mem_read, ex_mem_write <= 0; data regs don't-care.
REQ-023 Load-use hazard: hazard_stall=1 iff id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (id_rs==ex_rd | (!id_alusrc & id_rt==ex_rd)) & !stall_in.
REQ-024 hazard_stall=1 inserts bubble (as REQ-022) and bubble_cnt increments; ID re-presents same instruction next cycle.
REQ-025 bubble_cnt saturates at all-ones; flush does not increment it.
REQ-026 Forwarding combinational on registered rs/rt: EX/MEM match (exm_reg_write, exm_rd!=0, equal index) wins over MEM/WB match; else registered register-file value.
REQ-027 Index 0 never forwarded; register 0 operand taken from registered data unchanged.
REQ-028 in1 = forwarded rs; in2 = registered imm if alusrc else forwarded rt; ex_store_data = forwarded rt always.
REQ-029 ALUop = registered opcode; when ex_valid=0, ALUop=0 (ADD) with in1/in2 unconstrained.
REQ-030 Simultaneous flush and hazard: flush semantics, bubble_cnt unchanged.

Reset
REQ-031 rst=1 at edge: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write <= 0; ex_rd, ALUop, data regs <= 0; bubble_cnt <= 0.
REQ-032 Reset mid-operation discards in-flight instruction; stall_in and flush ignored during rst.

Verification
REQ-033 Load: id rs=3 data 5, rt=4 data 7, aluop 0 -> next cycle in1=5, in2=7, ex_valid=1.
REQ-034 Forward: EX rs=3; exm_rd=3 result 0x10, mwb_rd=3 data 0x20 -> in1=0x10; exm_reg_write=0 -> in1=0x20; rs=0 -> no forward.
REQ-035 Load-use: EX lw rd=8; ID add rs=8 -> hazard_stall=1, next cycle ex_valid=0, bubble_cnt=1; following cycle add enters.
REQ-036 alusrc=1, id_rt=8 equals load rd -> hazard_stall=0, in2=imm.
REQ-037 stall_in held 3 cycles with flush=1 -> EX registers and bubble_cnt unchanged; release -> flush applied.
REQ-038 rst during valid EX with bubble_cnt=5 -> all outputs 0 next cycle.
